// File: rtl/pmem_loader.sv
// pmem_loader: host-side program loader for the swt16 core.
// Takes a big-endian byte stream (word count, then data words) over a
// valid/ready handshake. Writes 16-bit words to program memory at
// consecutive instruction addresses. Holds the core stalled until the
// image is complete.
// Optional feature macro: PMEM_LOADER_CHECKSUM_EN adds a trailing 8-bit
// checksum byte. Release happens only when that byte matches the sum of
// all data bytes.
module pmem_loader #(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int PMEM_NUM_WORDS  = 2048,
    parameter int PC_INCREMENT    = 2
) (
    input  logic                       clock,
    input  logic                       reset,             // active-low, asynchronous
    input  logic                       in_valid,
    input  logic [7:0]                 in_byte,
    output logic                       out_ready,
    output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_wr_addr,
    output logic [PMEM_WORD_WIDTH-1:0] out_pmem_wr_word,
    output logic                       out_pmem_write_en,
    output logic                       out_cpu_hold,
    output logic                       out_done,
    output logic                       out_error
);

    typedef enum logic [2:0] {
        CNT_HI  = 3'd0,
        CNT_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } state_t;

    // State that follows the last data byte, or an empty image.
`ifdef PMEM_LOADER_CHECKSUM_EN
    localparam state_t FINISH_STATE = CHECK;
`else
    localparam state_t FINISH_STATE = DONE;
`endif

    state_t                     state;
    logic [7:0]                 cnt_hi;
    logic [15:0]                count;
    logic [PMEM_ADDR_WIDTH-1:0] index;
    logic [7:0]                 data_hi;
    logic                       write_en;
    logic [PMEM_ADDR_WIDTH-1:0] wr_addr;
    logic [PMEM_WORD_WIDTH-1:0] wr_word;
`ifdef PMEM_LOADER_CHECKSUM_EN
    logic [7:0]                 checksum;
`endif

    logic                       xfer;
    logic [15:0]                count_next;
    logic [PMEM_ADDR_WIDTH-1:0] index_next;

    assign xfer       = in_valid && out_ready;
    assign count_next = {cnt_hi, in_byte};
    assign index_next = index + PMEM_ADDR_WIDTH'(1);

    // Stream parser, word assembly and write-port registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= CNT_HI;
            cnt_hi   <= '0;
            count    <= '0;
            index    <= '0;
            data_hi  <= '0;
            write_en <= 1'b0;
            wr_addr  <= '0;
            wr_word  <= '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            write_en <= 1'b0;
            if (xfer) begin
                case (state)
                    CNT_HI: begin
                        cnt_hi <= in_byte;
                        state  <= CNT_LO;
                    end
                    CNT_LO: begin
                        count <= count_next;
                        if (32'(count_next) > PMEM_NUM_WORDS)
                            state <= ERROR;
                        else if (count_next == 16'd0)
                            state <= FINISH_STATE;
                        else
                            state <= DATA_HI;
                    end
                    DATA_HI: begin
                        data_hi <= in_byte;
`ifdef PMEM_LOADER_CHECKSUM_EN
                        checksum <= checksum + in_byte;
`endif
                        state   <= DATA_LO;
                    end
                    DATA_LO: begin
                        // The final write and the DONE transition land on the same edge.
                        write_en <= 1'b1;
                        wr_addr  <= PMEM_ADDR_WIDTH'(32'(index) * PC_INCREMENT);
                        wr_word  <= PMEM_WORD_WIDTH'({data_hi, in_byte});
                        index    <= index_next;
`ifdef PMEM_LOADER_CHECKSUM_EN
                        checksum <= checksum + in_byte;
`endif
                        if (32'(index_next) == 32'(count))
                            state <= FINISH_STATE;
                        else
                            state <= DATA_HI;
                    end
                    CHECK: begin
`ifdef PMEM_LOADER_CHECKSUM_EN
                        state <= (in_byte == checksum) ? DONE : ERROR;
`else
                        state <= ERROR;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status flags are decoded directly from the state register.
    assign out_ready         = (state != DONE) && (state != ERROR);
    assign out_cpu_hold      = (state != DONE);
    assign out_done          = (state == DONE);
    assign out_error         = (state == ERROR);
    assign out_pmem_write_en = write_en;
    assign out_pmem_wr_addr  = wr_addr;
    assign out_pmem_wr_word  = wr_word;

endmodule

// File: tb/tb_pmem_loader.sv
// Directed testbench for pmem_loader. It exercises both the default
// build and the PMEM_LOADER_CHECKSUM_EN build.
module tb_pmem_loader;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        out_ready;
    logic [11:0] out_pmem_wr_addr;
    logic [15:0] out_pmem_wr_word;
    logic        out_pmem_write_en;
    logic        out_cpu_hold;
    logic        out_done;
    logic        out_error;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [7:0]  stream [16];
    logic [11:0] wa_q [$];
    logic [15:0] ww_q [$];
    int          wc_q [$];
    logic        wd_q [$];
    logic        wh_q [$];

    pmem_loader dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_byte           (in_byte),
        .out_ready         (out_ready),
        .out_pmem_wr_addr  (out_pmem_wr_addr),
        .out_pmem_wr_word  (out_pmem_wr_word),
        .out_pmem_write_en (out_pmem_write_en),
        .out_cpu_hold      (out_cpu_hold),
        .out_done          (out_done),
        .out_error         (out_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cycle <= cycle + 1;

    // Record every write strobe, together with the status seen in that cycle.
    always @(negedge clock) begin
        if (out_pmem_write_en === 1'b1) begin
            wa_q.push_back(out_pmem_wr_addr);
            ww_q.push_back(out_pmem_wr_word);
            wc_q.push_back(cycle);
            wd_q.push_back(out_done);
            wh_q.push_back(out_cpu_hold);
            $display("write cycle=%0d addr=%03h word=%04h done=%0b hold=%0b",
                     cycle, out_pmem_wr_addr, out_pmem_wr_word, out_done, out_cpu_hold);
        end
    end

    task automatic clear_log();
        wa_q.delete(); ww_q.delete(); wc_q.delete(); wd_q.delete(); wh_q.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_byte  = 8'h00;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        clear_log();
    endtask

    // Present stream[0..n-1]. Each byte waits for acceptance, then the
    // driver idles for gap cycles.
    task automatic send_stream(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int   waited;
            logic ok;
            waited = 0;
            ok = 1'b0;
            in_valid = 1'b1;
            in_byte  = stream[i];
            while (!ok) begin
                ok = out_ready;
                @(posedge clock);
                #1;
                waited++;
                if (!ok && waited > 20) begin
                    total++; bad++;
                    $display("FAIL send_timeout byte=%0d got ready=%0b want 1", i, out_ready);
                    break;
                end
            end
            $display("byte %0d = %02h accepted=%0b", i, stream[i], ok);
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clock);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        #7;
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", out_ready); end
        total++; if (out_pmem_write_en !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", out_pmem_write_en); end
        total++; if (out_pmem_wr_addr !== 12'h000) begin bad++; $display("FAIL reset_addr got=%h want=000", out_pmem_wr_addr); end
        total++; if (out_pmem_wr_word !== 16'h0000) begin bad++; $display("FAIL reset_word got=%h want=0000", out_pmem_wr_word); end
        total++; if (out_cpu_hold !== 1'b1) begin bad++; $display("FAIL reset_hold got=%0b want=1", out_cpu_hold); end
        total++; if (out_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", out_done); end
        total++; if (out_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b want=0", out_error); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Three-word image, delivered with gap idle cycles between bytes.
    task automatic test_stream(input int gap);
        logic [11:0] exp_a [3];
        logic [15:0] exp_w [3];
        int n;
        exp_a[0] = 12'h000; exp_a[1] = 12'h002; exp_a[2] = 12'h004;
        exp_w[0] = 16'h1234; exp_w[1] = 16'hABCD; exp_w[2] = 16'h0007;
        do_reset();
        stream[0] = 8'h00; stream[1] = 8'h03; stream[2] = 8'h12; stream[3] = 8'h34;
        stream[4] = 8'hAB; stream[5] = 8'hCD; stream[6] = 8'h00; stream[7] = 8'h07;
        n = 8;
`ifdef PMEM_LOADER_CHECKSUM_EN
        stream[8] = 8'hC5;
        n = 9;
`endif
        send_stream(n, gap);
        repeat (3) @(negedge clock);
        total++;
        if (wa_q.size() !== 3) begin
            bad++; $display("FAIL img_count gap=%0d got=%0d want=3", gap, wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (wa_q[i] !== exp_a[i]) begin bad++; $display("FAIL img_addr%0d gap=%0d got=%h want=%h", i, gap, wa_q[i], exp_a[i]); end
                total++; if (ww_q[i] !== exp_w[i]) begin bad++; $display("FAIL img_word%0d gap=%0d got=%h want=%h", i, gap, ww_q[i], exp_w[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                total++;
                if (wc_q[i] - wc_q[i-1] !== 2 * (gap + 1)) begin
                    bad++; $display("FAIL img_spacing%0d gap=%0d got=%0d want=%0d", i, gap, wc_q[i] - wc_q[i-1], 2 * (gap + 1));
                end
            end
            total++; if (wh_q[0] !== 1'b1) begin bad++; $display("FAIL img_hold_first gap=%0d got=%0b want=1", gap, wh_q[0]); end
`ifndef PMEM_LOADER_CHECKSUM_EN
            total++; if (wd_q[2] !== 1'b1) begin bad++; $display("FAIL img_done_at_last gap=%0d got=%0b want=1", gap, wd_q[2]); end
            total++; if (wh_q[2] !== 1'b0) begin bad++; $display("FAIL img_hold_at_last gap=%0d got=%0b want=0", gap, wh_q[2]); end
`endif
        end
        total++; if (out_done !== 1'b1) begin bad++; $display("FAIL img_done gap=%0d got=%0b want=1", gap, out_done); end
        total++; if (out_cpu_hold !== 1'b0) begin bad++; $display("FAIL img_hold gap=%0d got=%0b want=0", gap, out_cpu_hold); end
        total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL img_ready gap=%0d got=%0b want=0", gap, out_ready); end
    endtask

    task automatic test_empty();
        do_reset();
        stream[0] = 8'h00; stream[1] = 8'h00;
        send_stream(2, 0);
`ifdef PMEM_LOADER_CHECKSUM_EN
        @(negedge clock);
        total++; if (out_done !== 1'b0) begin bad++; $display("FAIL empty_wait_done got=%0b want=0", out_done); end
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL empty_wait_ready got=%0b want=1", out_ready); end
        stream[0] = 8'h00;
        send_stream(1, 0);
`endif
        repeat (2) @(negedge clock);
        total++; if (wa_q.size() !== 0) begin bad++; $display("FAIL empty_writes got=%0d want=0", wa_q.size()); end
        total++; if (out_done !== 1'b1) begin bad++; $display("FAIL empty_done got=%0b want=1", out_done); end
        total++; if (out_cpu_hold !== 1'b0) begin bad++; $display("FAIL empty_hold got=%0b want=0", out_cpu_hold); end
    endtask

    task automatic test_overflow();
        do_reset();
        stream[0] = 8'h08; stream[1] = 8'h01;
        send_stream(2, 0);
        @(negedge clock);
        total++; if (out_error !== 1'b1) begin bad++; $display("FAIL ovf_error got=%0b want=1", out_error); end
        total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%0b want=0", out_ready); end
        // Extra bytes must be ignored while the error is sticky.
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        repeat (4) @(negedge clock);
        in_valid = 1'b0;
        total++; if (wa_q.size() !== 0) begin bad++; $display("FAIL ovf_writes got=%0d want=0", wa_q.size()); end
        total++; if (out_error !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", out_error); end
        total++; if (out_cpu_hold !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%0b want=1", out_cpu_hold); end
        total++; if (out_done !== 1'b0) begin bad++; $display("FAIL ovf_done got=%0b want=0", out_done); end
        // N equal to capacity is legal.
        do_reset();
        stream[0] = 8'h08; stream[1] = 8'h00;
        send_stream(2, 0);
        @(negedge clock);
        total++; if (out_error !== 1'b0) begin bad++; $display("FAIL cap_error got=%0b want=0", out_error); end
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL cap_ready got=%0b want=1", out_ready); end
    endtask

    task automatic test_reset_midload();
        int n;
        do_reset();
        stream[0] = 8'h00; stream[1] = 8'h02; stream[2] = 8'h11; stream[3] = 8'h22;
        send_stream(4, 0);
        // The strobe of the first word is visible now.
        total++; if (out_pmem_write_en !== 1'b1) begin bad++; $display("FAIL mid_strobe got=%0b want=1", out_pmem_write_en); end
        #1;
        reset = 1'b0;
        #1;
        total++; if (out_pmem_write_en !== 1'b0) begin bad++; $display("FAIL mid_we got=%0b want=0", out_pmem_write_en); end
        total++; if (out_pmem_wr_addr !== 12'h000) begin bad++; $display("FAIL mid_addr got=%h want=000", out_pmem_wr_addr); end
        total++; if (out_pmem_wr_word !== 16'h0000) begin bad++; $display("FAIL mid_word got=%h want=0000", out_pmem_wr_word); end
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0b want=1", out_ready); end
        total++; if (out_cpu_hold !== 1'b1) begin bad++; $display("FAIL mid_hold got=%0b want=1", out_cpu_hold); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        clear_log();
        stream[0] = 8'h00; stream[1] = 8'h01; stream[2] = 8'h55; stream[3] = 8'hAA;
        n = 4;
`ifdef PMEM_LOADER_CHECKSUM_EN
        stream[4] = 8'hFF;
        n = 5;
`endif
        send_stream(n, 0);
        repeat (3) @(negedge clock);
        total++;
        if (wa_q.size() !== 1) begin
            bad++; $display("FAIL fresh_count got=%0d want=1", wa_q.size());
        end else begin
            total++; if (wa_q[0] !== 12'h000) begin bad++; $display("FAIL fresh_addr got=%h want=000", wa_q[0]); end
            total++; if (ww_q[0] !== 16'h55AA) begin bad++; $display("FAIL fresh_word got=%h want=55AA", ww_q[0]); end
        end
        total++; if (out_done !== 1'b1) begin bad++; $display("FAIL fresh_done got=%0b want=1", out_done); end
    endtask

`ifdef PMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        stream[0] = 8'h00; stream[1] = 8'h01; stream[2] = 8'h10; stream[3] = 8'h20; stream[4] = 8'h30;
        send_stream(5, 0);
        @(negedge clock);
        total++; if (out_done !== 1'b1) begin bad++; $display("FAIL cks_ok_done got=%0b want=1", out_done); end
        do_reset();
        stream[4] = 8'h31;
        send_stream(5, 0);
        @(negedge clock);
        total++; if (out_error !== 1'b1) begin bad++; $display("FAIL cks_bad_error got=%0b want=1", out_error); end
        total++; if (out_cpu_hold !== 1'b1) begin bad++; $display("FAIL cks_bad_hold got=%0b want=1", out_cpu_hold); end
        total++;
        if (wa_q.size() !== 1) begin
            bad++; $display("FAIL cks_bad_count got=%0d want=1", wa_q.size());
        end else begin
            total++; if (wa_q[0] !== 12'h000) begin bad++; $display("FAIL cks_bad_addr got=%h want=000", wa_q[0]); end
            total++; if (ww_q[0] !== 16'h1020) begin bad++; $display("FAIL cks_bad_word got=%h want=1020", ww_q[0]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream(0);
        test_stream(1);
        test_empty();
        test_overflow();
        test_reset_midload();
`ifdef PMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
